pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The module SHALL have the parameter DRAIN_CYCLES, default 3, the number of bubble cycles needed to empty decode, execute and writeback after halt.
REQ-002 The module SHALL have the port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have the port rst_n_i, input, 1 bit, the reset: asynchronous and active-low.
REQ-004 The module SHALL have the port run_i, input, 1 bit, a level request to free-run.
REQ-005 The module SHALL have the port halt_i, input, 1 bit, a level request to stop and drain.
REQ-006 The module SHALL have the port step_i, input, 1 bit, a one-cycle pulse to advance one instruction.
REQ-007 The module SHALL have the ports rd_en_i, input, 1 bit, and rd_addr_a_i / rd_addr_b_i, input, 3 bits each, the register reads of the instruction in decode.
REQ-008 The module SHALL have the ports ex_wr_en_i, input, 1 bit, and ex_wr_addr_i, input, 3 bits, the pending write in execute.
REQ-009 The module SHALL have the ports wb_wr_en_i, input, 1 bit, and wb_wr_addr_i, input, 3 bits, the pending write in writeback.
REQ-010 The module SHALL have the port branch_req_i, input, 1 bit, the flag-qualified branch request from decode.
REQ-011 The module SHALL have the ports pc_en_o, fetch_en_o and branch_en_o, output, 1 bit each: PC advance, fetch-latch load and gated branch.
REQ-012 The module SHALL have the ports fetch_flush_o and decode_bubble_o, output, 1 bit each: zero the fetch latch, and load a NOP (wr_en=0) into the decode latch.
REQ-013 The module SHALL have the ports state_o, output, 2 bits (HALTED=0, RUN=1, STEP=2, DRAIN=3), and stall_cnt_o, output, 8 bits, the hazard-stall count.

Function
REQ-014 hazard SHALL equal rd_en_i & ((ex_wr_en_i & ex_wr_addr_i==rd_addr_a_i or rd_addr_b_i) | (wb_wr_en_i & wb_wr_addr_i==rd_addr_a_i or rd_addr_b_i)); register r0 is not exempt.
REQ-015 "active" SHALL be (state==RUN) | (state==STEP); advance = active & ~hazard.
REQ-016 pc_en_o = fetch_en_o = advance, combinationally.
REQ-017 decode_bubble_o SHALL be 1 when (active & hazard) or state is HALTED or DRAIN.
REQ-018 branch_en_o = branch_req_i & advance; a branch is never taken while stalled or halted.
REQ-019 fetch_flush_o = branch_en_o, squashing the wrong-path instruction in the same cycle.
REQ-020 HALTED SHALL go to RUN if run_i & ~halt_i; else to STEP if step_i; else stay HALTED.
REQ-021 RUN SHALL go to DRAIN, loading the drain counter with DRAIN_CYCLES-1, when halt_i=1 or run_i=0.
REQ-022 STEP SHALL go to HALTED in the cycle where advance=1, and stay in STEP while hazard=1; halt_i SHALL move STEP to DRAIN.
REQ-023 DRAIN SHALL decrement the counter each cycle and go to HALTED on the cycle it equals 0; run_i, step_i and branch_req_i are ignored in DRAIN.
REQ-024 When halt_i and run_i are both 1, halt_i SHALL win in every state; step_i SHALL be ignored outside HALTED.
REQ-025 stall_cnt_o SHALL increment on every cycle with active & hazard and saturate at 255.
REQ-026 Outputs SHALL depend only on current state and current inputs: no output registers, zero-cycle latency.

Reset
REQ-027 While rst_n_i=0, state SHALL be HALTED, the drain counter 0 and stall_cnt_o 0, so pc_en_o=fetch_en_o=branch_en_o=fetch_flush_o=0 and decode_bubble_o=1.
REQ-028 Reset assertion mid-RUN or mid-DRAIN SHALL take effect immediately without waiting for a clock; release SHALL be followed by at least one cycle in HALTED.

Verification
REQ-029 Reset, then run_i=1 with no hazards -> state_o 0 then 1, and pc_en_o=1 every cycle from the first RUN cycle.
REQ-030 RUN with rd_en_i=1, rd_addr_a_i=2, ex_wr_en_i=1, ex_wr_addr_i=2, then the same write moved to wb, then cleared -> 2 cycles with pc_en_o=0 and decode_bubble_o=1; stall_cnt_o rises by 2.
REQ-031 RUN with branch_req_i=1 and no hazard -> branch_en_o=1 and fetch_flush_o=1 for that cycle; the same request with a wb hazard -> branch_en_o=0.
REQ-032 halt_i pulse in RUN -> exactly 3 DRAIN cycles (pc_en_o=0, decode_bubble_o=1), then HALTED; run_i during DRAIN has no effect.
REQ-033 From HALTED, a step_i pulse with a hazard held for 2 cycles -> STEP for 3 cycles, pc_en_o=1 only in the third, then HALTED.
REQ-034 Force 300 consecutive stall cycles -> stall_cnt_o=255 and held; rst_n_i low mid-stall -> all outputs at reset values immediately.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Pipeline-side signals of the pipeline controller: decode reads, pending writes,
// branch request, and the fetch/decode control strobes the controller returns.
interface pipe_ctrl_if;
  logic       rd_en_i;
  logic [2:0] rd_addr_a_i;
  logic [2:0] rd_addr_b_i;
  logic       ex_wr_en_i;
  logic [2:0] ex_wr_addr_i;
  logic       wb_wr_en_i;
  logic [2:0] wb_wr_addr_i;
  logic       branch_req_i;
  logic       pc_en_o;
  logic       fetch_en_o;
  logic       branch_en_o;
  logic       fetch_flush_o;
  logic       decode_bubble_o;

  // Datapath side: presents hazard/branch info, consumes control strobes.
  modport master (
    output rd_en_i, rd_addr_a_i, rd_addr_b_i,
    output ex_wr_en_i, ex_wr_addr_i, wb_wr_en_i, wb_wr_addr_i, branch_req_i,
    input  pc_en_o, fetch_en_o, branch_en_o, fetch_flush_o, decode_bubble_o
  );

  // Controller side.
  modport slave (
    input  rd_en_i, rd_addr_a_i, rd_addr_b_i,
    input  ex_wr_en_i, ex_wr_addr_i, wb_wr_en_i, wb_wr_addr_i, branch_req_i,
    output pc_en_o, fetch_en_o, branch_en_o, fetch_flush_o, decode_bubble_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline run/step/halt controller with RAW hazard stalling, branch gating,
// post-halt drain sequencing and a saturating hazard-stall counter.
module pipe_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              run_i,
  input  logic              halt_i,
  input  logic              step_i,
  pipe_ctrl_if.slave        pipe_io,
  output logic [1:0]        state_o,
  output logic [7:0]        stall_cnt_o
);

  localparam int unsigned CntW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CntW-1:0] DrainLoad = CntW'(DRAIN_CYCLES - 1);

  localparam logic [1:0] StHalted = 2'd0;
  localparam logic [1:0] StRun    = 2'd1;
  localparam logic [1:0] StStep   = 2'd2;
  localparam logic [1:0] StDrain  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] drain_cnt_q, drain_cnt_d;
  logic [7:0]      stall_cnt_q, stall_cnt_d;

  logic ex_hit, wb_hit, hazard, active, advance;

  // r0 is deliberately not exempt: any matching pending write stalls.
  always_comb begin
    ex_hit  = pipe_io.ex_wr_en_i &
              ((pipe_io.ex_wr_addr_i == pipe_io.rd_addr_a_i) |
               (pipe_io.ex_wr_addr_i == pipe_io.rd_addr_b_i));
    wb_hit  = pipe_io.wb_wr_en_i &
              ((pipe_io.wb_wr_addr_i == pipe_io.rd_addr_a_i) |
               (pipe_io.wb_wr_addr_i == pipe_io.rd_addr_b_i));
    hazard  = pipe_io.rd_en_i & (ex_hit | wb_hit);
    active  = (state_q == StRun) | (state_q == StStep);
    advance = active & ~hazard;
  end

  always_comb begin
    pipe_io.pc_en_o         = advance;
    pipe_io.fetch_en_o      = advance;
    pipe_io.branch_en_o     = pipe_io.branch_req_i & advance;
    pipe_io.fetch_flush_o   = pipe_io.branch_req_i & advance;
    pipe_io.decode_bubble_o = (active & hazard) | (state_q == StHalted) |
                              (state_q == StDrain);
    state_o                 = state_q;
    stall_cnt_o             = stall_cnt_q;
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      StHalted: begin
        if (run_i && !halt_i) begin
          state_d = StRun;
        end else if (step_i) begin
          state_d = StStep;
        end
      end
      StRun: begin
        if (halt_i || !run_i) begin
          state_d     = StDrain;
          drain_cnt_d = DrainLoad;
        end
      end
      StStep: begin
        if (halt_i) begin
          state_d     = StDrain;
          drain_cnt_d = DrainLoad;
        end else if (advance) begin
          state_d = StHalted;
        end
      end
      StDrain: begin
        if (drain_cnt_q == '0) begin
          state_d = StHalted;
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end
      default: state_d = StHalted;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (active && hazard && (stall_cnt_q != 8'hFF)) begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StHalted;
      drain_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
